mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer.sv | 133 +++++++++++++
 tb/tb_mul_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Signed iterative multiplier for the exec stage.
// Radix-2 shift-add over REG_SIZE cycles, sign applied at the end.
module mul_sequencer #(
    parameter int REG_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [REG_SIZE-1:0] src1,
    input  logic [REG_SIZE-1:0] src2,
    input  logic                flush,
    output logic                stall,
    output logic                done,
    output logic [REG_SIZE-1:0] out,
    output logic                overflow
);

    localparam int CW = $clog2(REG_SIZE) + 1;
    localparam int PW = 2 * REG_SIZE;
    localparam logic [CW-1:0] LAST = CW'(REG_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PW-1:0]       acc;
    logic [PW-1:0]       mcand;
    logic [PW-1:0]       acc_step;
    logic [PW-1:0]       prod;
    logic [REG_SIZE-1:0] mplier;
    logic [REG_SIZE-1:0] abs1;
    logic [REG_SIZE-1:0] abs2;
    logic [CW-1:0]       cnt;
    logic                sign;
    logic                accept;
    logic                last;
    logic                ovf;
    logic [REG_SIZE:0]   hi;

    // Magnitudes as unsigned values; the most negative input maps to 2^(REG_SIZE-1).
    always_comb begin
        abs1 = src1[REG_SIZE-1] ? (~src1 + 1'b1) : src1;
        abs2 = src2[REG_SIZE-1] ? (~src2 + 1'b1) : src2;
    end

    // One shift-add step, plus the signed product as it would be after this step.
    always_comb begin
        acc_step = acc + (mplier[0] ? mcand : '0);
        prod     = sign ? (~acc_step + 1'b1) : acc_step;
        hi       = prod[PW-1:REG_SIZE-1];
        ovf      = !((&hi) || (~|hi));
        last     = (state == BUSY) && (cnt == LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: state_nxt = accept ? BUSY : IDLE;
            BUSY:       state_nxt = last ? DONE : BUSY;
            default:    state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // FSM outputs: acceptance, pipeline hold and result strobe.
    always_comb begin
        accept = 1'b0;
        stall  = 1'b0;
        done   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                accept = req_valid && !flush && !reset;
                stall  = accept;
                done   = (state == DONE) && !reset;
            end
            BUSY: begin
                stall = !reset;
            end
            default: begin
                accept = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and result registration.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            out      <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            acc    <= '0;
            cnt    <= '0;
            sign   <= src1[REG_SIZE-1] ^ src2[REG_SIZE-1];
            mplier <= abs2;
            mcand  <= {{REG_SIZE{1'b0}}, abs1};
        end else if (flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_step;
            mplier <= mplier >> 1;
            mcand  <= mcand << 1;
            cnt    <= cnt + 1'b1;
            if (last) begin
                out      <= prod[REG_SIZE-1:0];
                overflow <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed vector table, corner sequences
// and random traffic against a transaction-level reference.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        stall;
    logic        done;
    logic [31:0] out;
    logic        overflow;

    mul_sequencer #(.REG_SIZE(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .stall     (stall),
        .done      (done),
        .out       (out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    int          cyc = 0;
    int          done_at = -1;
    int          acc_cyc = -1;
    logic [31:0] m_out = '0;
    logic        m_ovf = 1'b0;
    logic [31:0] p_out = '0;
    logic        p_ovf = 1'b0;
    logic        r_prev = 1'b1;
    logic        obs_stall;
    logic        obs_done;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [32:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        logic [32:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = sa * sb;
        r[31:0] = p[31:0];
        r[32] = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later.
    task automatic run(input logic r, input logic v, input logic f,
                       input logic [31:0] a, input logic [31:0] b);
        bit busy;
        bit in_done;
        logic [32:0] res;
        @(negedge clk);
        reset = r;
        req_valid = v;
        flush = f;
        src1 = a;
        src2 = b;
        #1;
        busy = (acc_cyc >= 0) && (cyc > acc_cyc) && (cyc < done_at);
        in_done = (done_at >= 0) && (cyc == done_at);
        if (in_done) begin
            m_out = p_out;
            m_ovf = p_ovf;
        end
        obs_stall = stall;
        obs_done = done;
        if (!(r && !r_prev)) begin
            chk("done", {31'd0, done}, {31'd0, in_done && !r});
            chk("stall", {31'd0, stall}, {31'd0, !r && (busy || (v && !f))});
        end
        chk("out", out, m_out);
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (r) begin
            m_out = '0;
            m_ovf = 1'b0;
            done_at = -1;
            acc_cyc = -1;
        end else if (f) begin
            done_at = -1;
            acc_cyc = -1;
        end else if (v && !busy) begin
            acc_cyc = cyc;
            done_at = cyc + 33;
            res = ref_mul(a, b);
            p_out = res[31:0];
            p_ovf = res[32];
        end
        r_prev = r;
        cyc++;
    endtask

    task automatic idle_until_done(input int lim, output int lat,
                                   output int stalls);
        bit seen;
        seen = 0;
        lat = 0;
        stalls = 0;
        while (!seen && lat < lim) begin
            run(1'b0, 1'b0, 1'b0, $urandom, $urandom);
            lat++;
            if (obs_stall) stalls++;
            if (obs_done) seen = 1;
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c[5];
        c[0] = 32'h0;
        c[1] = 32'h1;
        c[2] = 32'hFFFF_FFFF;
        c[3] = 32'h8000_0000;
        c[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int lat;
        int st;
        logic r;
        logic v;
        logic f;

        tbl[0]  = '{32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        tbl[1]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        tbl[2]  = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        tbl[3]  = '{32'h0000_7FFF, 32'd2,         32'h0000_FFFE, 1'b0};
        tbl[4]  = '{32'd5,         32'd6,         32'd30,        1'b0};
        tbl[5]  = '{32'd0,         32'h1234_5678, 32'd0,         1'b0};
        tbl[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0};
        tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 32'd0,         1'b1};
        tbl[8]  = '{32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0};
        tbl[9]  = '{32'h4000_0000, 32'd2,         32'h8000_0000, 1'b1};
        tbl[10] = '{32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0};

        // reset state
        run(1'b1, 1'b0, 1'b0, '0, '0);
        run(1'b1, 1'b1, 1'b0, 32'd3, 32'd4);
        run(1'b0, 1'b0, 1'b0, '0, '0);

        // stall length and latency for a single request
        run(1'b0, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("issue_stall", {31'd0, obs_stall}, 32'd1);
        idle_until_done(40, lat, st);
        chk("lat_single", lat, 32'd33);
        chk("stall_cycles", st + 1, 32'd33);
        chk("out_single", out, 32'hFFFF_FFEB);

        // vector table
        for (int i = 0; i < 11; i++) begin
            run(1'b0, 1'b1, 1'b0, tbl[i].a, tbl[i].b);
            idle_until_done(40, lat, st);
            chk("tbl_lat", lat, 32'd33);
            chk("tbl_out", out, tbl[i].exp_out);
            chk("tbl_ovf", {31'd0, overflow}, {31'd0, tbl[i].exp_ovf});
        end

        // back-to-back issue in the DONE cycle
        run(1'b0, 1'b1, 1'b0, 32'd100, 32'd200);
        repeat (32) run(1'b0, 1'b0, 1'b0, $urandom, $urandom);
        run(1'b0, 1'b1, 1'b0, 32'd5, 32'd6);
        chk("b2b_done1", {31'd0, obs_done}, 32'd1);
        chk("b2b_out1", out, 32'd20000);
        idle_until_done(40, lat, st);
        chk("b2b_lat", lat, 32'd33);
        chk("b2b_out2", out, 32'd30);

        // flush at busy cycle 10
        run(1'b0, 1'b1, 1'b0, 32'd9, 32'd9);
        repeat (9) run(1'b0, 1'b0, 1'b0, $urandom, $urandom);
        run(1'b0, 1'b0, 1'b1, $urandom, $urandom);
        idle_until_done(40, lat, st);
        chk("flush_nodone", lat, 32'd40);
        chk("flush_out", out, 32'd30);
        run(1'b0, 1'b1, 1'b1, 32'd3, 32'd3);
        chk("flush_req_stall", {31'd0, obs_stall}, 32'd0);
        idle_until_done(40, lat, st);
        chk("flush_req_nodone", lat, 32'd40);

        // reset mid-busy, then a fresh request
        run(1'b0, 1'b1, 1'b0, 32'd12345, 32'd678);
        repeat (15) run(1'b0, 1'b0, 1'b0, $urandom, $urandom);
        run(1'b1, 1'b1, 1'b1, $urandom, $urandom);
        run(1'b0, 1'b0, 1'b0, '0, '0);
        chk("rst_out", out, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_done", {31'd0, obs_done}, 32'd0);
        chk("rst_stall", {31'd0, obs_stall}, 32'd0);
        run(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        idle_until_done(40, lat, st);
        chk("rst_lat", lat, 32'd33);
        chk("rst_new_out", out, 32'd4);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 199) < 2);
            f = ($urandom_range(0, 99) < 3);
            v = ($urandom_range(0, 99) < 40);
            run(r, v, f, pick(), pick());
        end
        repeat (40) run(1'b0, 1'b0, 1'b0, $urandom, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
